// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The FSM encoding is fixed so the unused code 2'b11 can be steered back to IDLE.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Bit-counter width; WIDTH >= 2 keeps this at least one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = ai - bi - bw, with borrow-out.
// Purely combinational so it can be exercised stand-alone with a truth table.
module full_subtractor_bit (
    input  logic ai,
    input  logic bi,
    input  logic bw,
    output logic d,
    output logic bw_next
);

    assign d       = ai ^ bi ^ bw;
    assign bw_next = (~ai & bi) | (~(ai ^ bi) & bw);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b), LSB first, one bit per clock
// through a single full-subtractor cell with a registered borrow.
//
// state | meaning
// IDLE  | waiting for start; diff/bout hold the last completed result
// RUN   | one bit processed per edge, WIDTH edges in total
// DONE  | one-cycle done pulse; start here chains straight into RUN
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;

    logic               w_accept;
    logic               w_run;
    logic               w_last;
    logic               w_d;
    logic               w_bw_next;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_unused_res;

    full_subtractor_bit u_cell (
        .ai      (r_a_sh[0]),
        .bi      (r_b_sh[0]),
        .bw      (r_borrow),
        .d       (w_d),
        .bw_next (w_bw_next)
    );

    assign w_run    = (r_state == RUN);
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = w_run && (r_count == CNT_W'(WIDTH - 1));

    // Each new bit enters at the MSB, so after WIDTH shifts bit 0 is at the LSB.
    assign w_res_next   = {w_d, r_res_sh[WIDTH-1:1]};
    assign w_unused_res = r_res_sh[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE:    w_state_nxt = start ? RUN : IDLE;
            RUN:     w_state_nxt = w_last ? DONE : RUN;
            DONE:    w_state_nxt = start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_res_sh <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
        end else if (w_run) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_res_sh <= w_res_next;
            r_borrow <= w_bw_next;
            if (w_last) begin
                r_count <= '0;
                r_diff  <= w_res_next;
                r_bout  <= w_bw_next;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8 and WIDTH=4 instances) and the
// full_subtractor_bit cell; expected results are queued at start, checked at done.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, bout4;
    logic [3:0] diff4;

    logic       c_ai = 1'b0, c_bi = 1'b0, c_bw = 1'b0;
    logic       c_d, c_bw_next;

    int         n_tests = 0;
    int         n_fail = 0;
    int         done8_cnt = 0;
    logic [8:0] q8[$];
    logic [4:0] q4[$];

    logic [7:0] tab_a[5] = '{8'd37, 8'd0, 8'd0, 8'd255, 8'd255};
    logic [7:0] tab_b[5] = '{8'd100, 8'd1, 8'd0, 8'd255, 8'd0};

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );

    full_subtractor_bit u_cell (
        .ai(c_ai), .bi(c_bi), .bw(c_bw), .d(c_d), .bw_next(c_bw_next)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        d = a - b;
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        q8.push_back({(a < b), d});
        tick();
        start8 = 1'b0;
    endtask

    task automatic go4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] d;
        d = a - b;
        a4 = a;
        b4 = b;
        start4 = 1'b1;
        q4.push_back({(a < b), d});
        tick();
        start4 = 1'b0;
    endtask

    task automatic wait_done8(input string tag);
        int n = 0;
        while (done8 !== 1'b1 && n < 24) begin
            tick();
            n++;
        end
        check(tag, {31'd0, done8}, 32'd1);
    endtask

    task automatic wait_done4(input string tag);
        int n = 0;
        while (done4 !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        check(tag, {31'd0, done4}, 32'd1);
    endtask

    // Scoreboards: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            done8_cnt++;
            if (q8.size() == 0) begin
                check("unexpected_done8", {31'd0, done8}, 32'd0);
            end else begin
                logic [8:0] e;
                e = q8.pop_front();
                check("diff8", {24'd0, diff8}, {24'd0, e[7:0]});
                check("bout8", {31'd0, bout8}, {31'd0, e[8]});
            end
        end
        if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
                check("unexpected_done4", {31'd0, done4}, 32'd0);
            end else begin
                logic [4:0] e;
                e = q4.pop_front();
                check("diff4", {28'd0, diff4}, {28'd0, e[3:0]});
                check("bout4", {31'd0, bout4}, {31'd0, e[4]});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_snap;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_busy8", {31'd0, busy8}, 32'd0);
        check("rst_done8", {31'd0, done8}, 32'd0);
        check("rst_diff8", {24'd0, diff8}, 32'd0);
        check("rst_bout8", {31'd0, bout8}, 32'd0);
        check("rst_busy4", {31'd0, busy4}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic subtract with exact latency: 8 busy cycles then one done cycle
        go8(8'd100, 8'd37);
        for (int i = 0; i < 8; i++) begin
            check("basic_busy", {31'd0, busy8}, 32'd1);
            check("basic_nodone", {31'd0, done8}, 32'd0);
            tick();
        end
        check("basic_done", {31'd0, done8}, 32'd1);
        check("basic_busy_low", {31'd0, busy8}, 32'd0);
        tick();
        check("basic_done_pulse", {31'd0, done8}, 32'd0);
        tick();
        tick();
        check("basic_hold_diff", {24'd0, diff8}, 32'd63);
        check("basic_hold_bout", {31'd0, bout8}, 32'd0);

        // Negative results and edge values
        for (int i = 0; i < 5; i++) begin
            go8(tab_a[i], tab_b[i]);
            wait_done8("table_done");
            tick();
        end

        // start during RUN is ignored, as are operand changes
        go8(8'd5, 8'd2);
        tick();
        tick();
        a8 = 8'd9;
        b8 = 8'd9;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'd77;
        wait_done8("ignore_done");
        check("ignore_diff", {24'd0, diff8}, 32'd3);
        tick();
        check("ignore_idle_busy", {31'd0, busy8}, 32'd0);
        check("ignore_idle_done", {31'd0, done8}, 32'd0);

        // start held in the done cycle chains a second operation
        go8(8'd50, 8'd8);
        wait_done8("b2b_first_done");
        go8(8'd10, 8'd4);
        check("b2b_busy", {31'd0, busy8}, 32'd1);
        wait_done8("b2b_second_done");
        check("b2b_diff", {24'd0, diff8}, 32'd6);
        tick();

        // Reset mid-operation aborts with no later done
        go8(8'd200, 8'd1);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        void'(q8.pop_back());
        tick();
        rst_n = 1'b1;
        check("midrst_busy", {31'd0, busy8}, 32'd0);
        check("midrst_done", {31'd0, done8}, 32'd0);
        check("midrst_diff", {24'd0, diff8}, 32'd0);
        check("midrst_bout", {31'd0, bout8}, 32'd0);
        cnt_snap = done8_cnt;
        repeat (15) tick();
        check("midrst_no_done", done8_cnt, cnt_snap);

        // Reset wins over a simultaneous start
        rst_n = 1'b0;
        a8 = 8'd3;
        b8 = 8'd1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        rst_n = 1'b1;
        check("rst_vs_start_busy", {31'd0, busy8}, 32'd0);
        tick();
        check("rst_vs_start_idle", {31'd0, busy8}, 32'd0);

        // Exhaustive sweep at WIDTH=4
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                go4(4'(ia), 4'(ib));
                wait_done4("sweep_done");
                tick();
            end
        end

        // Full-subtractor cell truth table
        for (int i = 0; i < 8; i++) begin
            int r;
            c_ai = i[2];
            c_bi = i[1];
            c_bw = i[0];
            #1;
            r = int'(c_ai) - int'(c_bi) - int'(c_bw);
            check("cell_d", {31'd0, c_d}, {31'd0, (r & 1) != 0});
            check("cell_bw", {31'd0, c_bw_next}, {31'd0, r < 0});
        end

        check("q8_drained", q8.size(), 32'd0);
        check("q4_drained", q4.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
